mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (ibus/dbus) to single-memory arbiter with dbus priority,
// ibus anti-starvation, a one-cycle IDLE bubble between grants and a BUSY timeout abort.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned STARVE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_ibus_req,
  input  logic        I_ibus_we,
  input  logic [31:0] I_ibus_addr,
  input  logic [31:0] I_ibus_data,
  input  logic [3:0]  I_ibus_mask,
  output logic [31:0] O_ibus_data,
  output logic        O_ibus_ready,
  input  logic        I_dbus_req,
  input  logic        I_dbus_we,
  input  logic [31:0] I_dbus_addr,
  input  logic [31:0] I_dbus_data,
  input  logic [3:0]  I_dbus_mask,
  output logic [31:0] O_dbus_data,
  output logic        O_dbus_ready,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_data,
  output logic [3:0]  O_mem_mask,
  input  logic [31:0] I_mem_data,
  input  logic        I_mem_ready,
  output logic        O_bus_err
);

  localparam int unsigned TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam int unsigned ST_W = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE);
  localparam logic [31:0]     ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state, state_nxt;
  logic [ST_W-1:0] starve_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            hold_we;
  logic [31:0]     hold_addr;
  logic [31:0]     hold_data;
  logic [3:0]      hold_mask;

  logic grant_i, grant_d, busy, timed_out, done;

  assign busy      = (state != IDLE);
  assign timed_out = busy && (to_cnt == TO_MAX);
  assign done      = busy && (I_mem_ready || timed_out);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (I_ibus_req && I_dbus_req) begin
          if (starve_cnt == ST_MAX) grant_i = 1'b1;
          else                      grant_d = 1'b1;
        end else if (I_ibus_req) begin
          grant_i = 1'b1;
        end else if (I_dbus_req) begin
          grant_d = 1'b1;
        end
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        // Always return through IDLE, which forces the one-cycle bubble.
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; the holding registers are cleared too so nothing stale leaks out.
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_mask  <= '0;
    end else begin
      state <= state_nxt;

      if (grant_i || grant_d) begin
        to_cnt    <= '0;
        hold_we   <= grant_i ? I_ibus_we   : I_dbus_we;
        hold_addr <= grant_i ? I_ibus_addr : I_dbus_addr;
        hold_data <= grant_i ? I_ibus_data : I_dbus_data;
        hold_mask <= grant_i ? I_ibus_mask : I_dbus_mask;
      end else if (busy && !I_mem_ready) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      // Count dbus wins that left ibus waiting; an ibus win resets the tally.
      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && I_ibus_req && (starve_cnt != ST_MAX)) begin
        starve_cnt <= starve_cnt + ST_W'(1);
      end
    end
  end

  always_comb begin
    O_mem_req    = busy;
    O_mem_we     = 1'b0;
    O_mem_addr   = '0;
    O_mem_data   = '0;
    O_mem_mask   = '0;
    O_ibus_ready = 1'b0;
    O_ibus_data  = '0;
    O_dbus_ready = 1'b0;
    O_dbus_data  = '0;
    O_bus_err    = 1'b0;

    if (busy) begin
      O_mem_we   = hold_we;
      O_mem_addr = hold_addr;
      O_mem_data = hold_data;
      O_mem_mask = hold_mask;
    end

    // A real completion beats a timeout landing in the same cycle.
    if (state == BUSY_I && done) begin
      O_ibus_ready = 1'b1;
      O_ibus_data  = I_mem_ready ? I_mem_data : ABORT_DATA;
    end
    if (state == BUSY_D && done) begin
      O_dbus_ready = 1'b1;
      O_dbus_data  = I_mem_ready ? I_mem_data : ABORT_DATA;
    end
    O_bus_err = timed_out && !I_mem_ready;
  end

endmodule
